multicycle_controller: RTL and testbench

- Multi-cycle RV32I control FSM. It sequences one instruction through FETCH, DECODE, EXEC, MEM and WB states.
- It drives datapath select/enable strobes and handshakes with instruction and data memories that have variable latency.
- It generalises the single-cycle decoder with the following:
  - full base-ISA opcode coverage: OP, OP-IMM, LOAD, STORE, BRANCH (all six), JAL, JALR, LUI, AUIPC;
  - branch resolution from ALU flags;
  - memory wait states;
  - a bounded memory timeout.
- It sits between the instruction register (which supplies opcode/func fields) and the datapath muxes/register file/PC register.

---
 rtl/multicycle_controller_if.sv | 67 ++++++
 rtl/multicycle_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Bundles everything that passes between the multi-cycle control FSM and the
// rest of the core: instruction-register fields, ALU flags, the memory
// handshake and the datapath select/enable strobes.
//
// Handshake: instr_mem_req / data_mem_req act as "valid" and mem_ready as
// "ready". A transfer completes in a cycle where the request and mem_ready
// are both high. Once raised, a request stays high, and its qualifiers
// (data_mem_write, ALU selections forming the address) stay stable, until
// that completing cycle. mem_ready with no request pending is ignored.
//
// Signals (direction seen from the controller, modport master):
//   in : opcode[6:0], func3[2:0], func7_5   instruction-register fields
//   in : alu_zero, alu_lt, alu_ltu          ALU comparison flags
//   in : mem_ready                          memory completes this cycle
//   out: instr_mem_req, ir_write            instruction fetch
//   out: data_mem_req, data_mem_write       data access (1=store)
//   out: alu_control[ALU_CTRL_W-1:0]        {func7_5,func3} style encoding
//   out: alu_src_a[1:0], alu_src_b[1:0]     operand muxes
//   out: imm_type[2:0]                      immediate generator format
//   out: reg_write, wb_sel[1:0]             register-file write port
//   out: pc_write, pc_source[1:0]           PC register update
//   out: fault, illegal                     sticky error flags
// The datapath side uses modport slave.
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic                  func7_5;
    logic                  alu_zero;
    logic                  alu_lt;
    logic                  alu_ltu;
    logic                  mem_ready;

    logic                  instr_mem_req;
    logic                  ir_write;
    logic                  data_mem_req;
    logic                  data_mem_write;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [2:0]            imm_type;
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic                  pc_write;
    logic [1:0]            pc_source;
    logic                  fault;
    logic                  illegal;

    modport master (
        input  opcode, func3, func7_5, alu_zero, alu_lt, alu_ltu, mem_ready,
        output instr_mem_req, ir_write, data_mem_req, data_mem_write,
               alu_control, alu_src_a, alu_src_b, imm_type,
               reg_write, wb_sel, pc_write, pc_source, fault, illegal
    );

    modport slave (
        output opcode, func3, func7_5, alu_zero, alu_lt, alu_ltu, mem_ready,
        input  instr_mem_req, ir_write, data_mem_req, data_mem_write,
               alu_control, alu_src_a, alu_src_b, imm_type,
               reg_write, wb_sel, pc_write, pc_source, fault, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle RV32I control FSM. Sequences one instruction at a time through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath strobes.
// Instruction and data memories have variable latency; a wait in FETCH or MEM
// longer than MEM_TIMEOUT cycles parks the FSM in HALT with fault set.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; forces every output to 0
//   bus        multicycle_controller_if.master (IR fields, flags, memory
//              handshake, datapath strobes, fault/illegal)
//   state_dbg  current FSM state for observation only
//
// Parameters:
//   ALU_CTRL_W   width of alu_control (>= 4), encoding {func7_5,func3}
//   MEM_TIMEOUT  max cycles waiting for mem_ready; 0 disables the timeout
//
// Build option:
//   CONTROLLER_ILLEGAL_TRAP_EN  when defined, an unrecognised opcode halts
//                               the FSM and sets the sticky illegal flag;
//                               otherwise it retires as a NOP.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        bus,
    output logic [2:0]                     state_dbg
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_NONE
    } cls_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PCS_PC4 = 2'd0;
    localparam logic [1:0] PCS_IMM = 2'd1;
    localparam logic [1:0] PCS_ALU = 2'd2;

    // Wait counter sized to hold MEM_TIMEOUT; kept at one bit when disabled.
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               fault_q;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
    logic               illegal_q;
`endif

    cls_t               cls;
    logic               taken;
    logic [3:0]         sel_alu;
    logic [1:0]         sel_a;
    logic [1:0]         sel_b;
    logic [2:0]         sel_imm;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Opcode classification. The IR holds the opcode stable from DECODE on,
    // so decoding it combinationally in every later state is safe.
    // -------------------------------------------------------------------------
    always_comb begin
        cls = CLS_NONE;
        case (bus.opcode)
            OPC_OP:     cls = CLS_OP;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            default:    cls = CLS_NONE;
        endcase
    end

    // Branch resolution from the SUB flags; func3 010/011 never branch.
    always_comb begin
        taken = 1'b0;
        case (bus.func3)
            3'b000:  taken = bus.alu_zero;
            3'b001:  taken = !bus.alu_zero;
            3'b100:  taken = bus.alu_lt;
            3'b101:  taken = !bus.alu_lt;
            3'b110:  taken = bus.alu_ltu;
            3'b111:  taken = !bus.alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    // ALU operation and operand selections per class. These are driven from
    // EXEC through WB so the address stays valid across MEM wait states.
    always_comb begin
        sel_alu = ALU_ADD;
        sel_a   = SRC_A_RS1;
        sel_b   = SRC_B_RS2;
        sel_imm = IMM_I;
        case (cls)
            CLS_OP: begin
                sel_alu = {bus.func7_5, bus.func3};
            end
            CLS_OP_IMM: begin
                // Only SRLI/SRAI use IR[30]; for other OP-IMM ops it is
                // immediate data and must not turn ADDI into SUB.
                sel_alu = {bus.func7_5 & (bus.func3 == 3'b101), bus.func3};
                sel_b   = SRC_B_IMM;
            end
            CLS_LOAD: begin
                sel_b   = SRC_B_IMM;
            end
            CLS_STORE: begin
                sel_b   = SRC_B_IMM;
                sel_imm = IMM_S;
            end
            CLS_BRANCH: begin
                sel_alu = ALU_SUB;
                sel_imm = IMM_B;
            end
            CLS_JAL: begin
                sel_a   = SRC_A_PC;
                sel_b   = SRC_B_IMM;
                sel_imm = IMM_J;
            end
            CLS_JALR: begin
                sel_b   = SRC_B_IMM;
            end
            CLS_LUI: begin
                sel_a   = SRC_A_ZERO;
                sel_b   = SRC_B_IMM;
                sel_imm = IMM_U;
            end
            CLS_AUIPC: begin
                sel_a   = SRC_A_PC;
                sel_b   = SRC_B_IMM;
                sel_imm = IMM_U;
            end
            default: ;
        endcase
    end

    // The counter never stores MEM_TIMEOUT itself: the cycle whose increment
    // would reach the limit is the one that diverts to HALT, unless
    // mem_ready arrives in that same cycle.
    assign cnt_inc     = wait_cnt + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && !bus.mem_ready &&
                         (cnt_inc == CNT_W'(MEM_TIMEOUT));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= S_HALT;
                        fault_q  <= 1'b1;
                        wait_cnt <= '0;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= cnt_inc;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
                    if (cls == CLS_NONE) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end
`endif
                end
                S_EXEC: begin
                    case (cls)
                        CLS_BRANCH, CLS_NONE: state <= S_FETCH;
                        CLS_LOAD, CLS_STORE:  state <= S_MEM;
                        default:              state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        state    <= (cls == CLS_STORE) ? S_FETCH : S_WB;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= S_HALT;
                        fault_q  <= 1'b1;
                        wait_cnt <= '0;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= cnt_inc;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state, IR fields and flags. Everything is forced
    // low while rst is high so an aborted instruction cannot commit.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.instr_mem_req  = 1'b0;
        bus.ir_write       = 1'b0;
        bus.data_mem_req   = 1'b0;
        bus.data_mem_write = 1'b0;
        bus.alu_control    = '0;
        bus.alu_src_a      = SRC_A_RS1;
        bus.alu_src_b      = SRC_B_RS2;
        bus.imm_type       = IMM_I;
        bus.reg_write      = 1'b0;
        bus.wb_sel         = WB_ALU;
        bus.pc_write       = 1'b0;
        bus.pc_source      = PCS_PC4;
        bus.fault          = 1'b0;
        bus.illegal        = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.instr_mem_req = 1'b1;
                    bus.ir_write      = bus.mem_ready;
                end
                S_EXEC: begin
                    if (cls == CLS_BRANCH) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = taken ? PCS_IMM : PCS_PC4;
                    end else if (cls == CLS_NONE) begin
                        // Unrecognised opcode retires as a NOP.
                        bus.pc_write  = 1'b1;
                        bus.pc_source = PCS_PC4;
                    end
                end
                S_MEM: begin
                    bus.data_mem_req   = 1'b1;
                    bus.data_mem_write = (cls == CLS_STORE);
                    if (bus.mem_ready && (cls == CLS_STORE)) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = PCS_PC4;
                    end
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    case (cls)
                        CLS_LOAD: begin
                            bus.wb_sel    = WB_MEM;
                            bus.pc_source = PCS_PC4;
                        end
                        CLS_JAL: begin
                            bus.wb_sel    = WB_PC4;
                            bus.pc_source = PCS_IMM;
                        end
                        CLS_JALR: begin
                            bus.wb_sel    = WB_PC4;
                            bus.pc_source = PCS_ALU;
                        end
                        default: begin
                            bus.wb_sel    = WB_ALU;
                            bus.pc_source = PCS_PC4;
                        end
                    endcase
                end
                default: ;
            endcase

            if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
                bus.alu_control = ALU_CTRL_W'(sel_alu);
                bus.alu_src_a   = sel_a;
                bus.alu_src_b   = sel_b;
                bus.imm_type    = sel_imm;
            end

            bus.fault = fault_q;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
            bus.illegal = illegal_q;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Drives instructions through the controller with a responding memory model
// and compares a per-instruction summary (latency, strobe counts, selections)
// against a reference computed from the instruction class rules.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TO       = 4;
    localparam int N_ITEMS  = 16;
    localparam int N_RANDOM = 200;

    logic       clk;
    logic       rst;
    logic [2:0] state_dbg;

    multicycle_controller_if #(.ALU_CTRL_W(4)) bus ();

    multicycle_controller #(
        .ALU_CTRL_W (4),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];

    logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                            7'h67, 7'h37, 7'h17, 7'h7F, 7'h00, 7'h73};

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string tag_of(input int i);
        case (i)
            0:  return "cycles";
            1:  return "ir_write_count";
            2:  return "ir_write_cycle";
            3:  return "pc_write_count";
            4:  return "pc_source";
            5:  return "reg_write_count";
            6:  return "reg_write_cycle";
            7:  return "wb_sel";
            8:  return "data_req_cycles";
            9:  return "data_mem_write";
            10: return "alu_control";
            11: return "alu_src_a";
            12: return "alu_src_b";
            13: return "imm_type";
            14: return "fault";
            default: return "illegal";
        endcase
    endfunction

    function automatic logic [31:0] outs_no_flags();
        return {11'b0, bus.instr_mem_req, bus.ir_write, bus.data_mem_req,
                bus.data_mem_write, bus.alu_control, bus.alu_src_a, bus.alu_src_b,
                bus.imm_type, bus.reg_write, bus.wb_sel, bus.pc_write, bus.pc_source};
    endfunction

    function automatic logic [31:0] all_outs();
        return (outs_no_flags() << 2) | {30'b0, bus.fault, bus.illegal};
    endfunction

    // ------------------------------------------------------ reference model
    task automatic push(input bit v, input int val);
        exp_q.push_back({v, 32'(val)});
    endtask

    task automatic model_instr(input logic [31:0] ins, input int fw, input int mw,
                               input logic z, input logic lt, input logic ltu);
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int cyc, pcs, rw, wb, dreq, dw, alu, sa, sb, imm;
        bit alu_v, src_v, imm_v, taken;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[30];
        cyc = fw + 4; pcs = 0; rw = 1; wb = 0; dreq = 0; dw = 0;
        alu = 0; sa = 0; sb = 0; imm = 0;
        alu_v = 1; src_v = 1; imm_v = 1; taken = 0;
        case (op)
            7'h33: begin alu = {f7, f3}; imm_v = 0; end
            7'h13: begin alu = {f7 && (f3 == 3'd5), f3}; sb = 1; end
            7'h03: begin cyc = fw + mw + 5; wb = 1; dreq = mw + 1; sb = 1; end
            7'h23: begin cyc = fw + mw + 4; rw = 0; dreq = mw + 1; dw = 1; sb = 1; imm = 1; end
            7'h63: begin
                cyc = fw + 3; rw = 0; alu = 8; imm = 2;
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4: taken = lt;
                    3'd5: taken = !lt;
                    3'd6: taken = ltu;
                    3'd7: taken = !ltu;
                    default: taken = 0;
                endcase
                pcs = taken ? 1 : 0;
            end
            7'h6F: begin wb = 2; pcs = 1; alu_v = 0; src_v = 0; imm = 4; end
            7'h67: begin wb = 2; pcs = 2; sb = 1; end
            7'h37: begin sa = 2; sb = 1; imm = 3; end
            7'h17: begin sa = 1; sb = 1; imm = 3; end
            default: begin cyc = fw + 3; rw = 0; alu_v = 0; src_v = 0; imm_v = 0; end
        endcase
        push(1, cyc);
        push(1, 1);
        push(1, fw + 1);
        push(1, 1);
        push(1, pcs);
        push(1, rw);
        push(rw != 0, cyc);
        push(rw != 0, wb);
        push(1, dreq);
        push(dreq != 0, dw);
        push(alu_v, alu);
        push(src_v, sa);
        push(src_v, sb);
        push(imm_v, imm);
        push(1, 0);
        push(1, 0);
    endtask

    // -------------------------------------------------------------- drivers
    task automatic drive_instr(input logic [31:0] ins, input logic z, input logic lt, input logic ltu);
        bus.opcode   = ins[6:0];
        bus.func3    = ins[14:12];
        bus.func7_5  = ins[30];
        bus.alu_zero = z;
        bus.alu_lt   = lt;
        bus.alu_ltu  = ltu;
    endtask

    // Entered and left just after a rising edge with the FSM in FETCH.
    task automatic do_reset(input string tag, input logic ready_during);
        rst = 1'b1;
        bus.mem_ready = ready_during;
        @(negedge clk);
        check({tag, "_outputs_zero"}, all_outs(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check({tag, "_fetch_after_reset"}, 32'(bus.instr_mem_req), 32'd1);
        check({tag, "_fault_clear"}, 32'(bus.fault), 32'd0);
    endtask

    // Runs one instruction with a memory that answers after fw / mw waits.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic lt, input logic ltu);
        int obs[N_ITEMS];
        int fwaits, mwaits;
        bit done;
        logic [32:0] e;
        for (int i = 0; i < N_ITEMS; i++) obs[i] = 0;
        fwaits = 0;
        mwaits = 0;
        done   = 0;
        model_instr(ins, fw, mw, z, lt, ltu);
        drive_instr(ins, z, lt, ltu);
        for (int c = 1; c <= 40 && !done; c++) begin
            bus.mem_ready = (bus.instr_mem_req && fwaits == fw) ||
                            (bus.data_mem_req && mwaits == mw);
            @(negedge clk);
            if (bus.ir_write) begin obs[1]++; obs[2] = c; end
            if (bus.pc_write) begin
                obs[3]++;
                obs[4] = int'(bus.pc_source);
                obs[0] = c;
                done = 1;
            end
            if (bus.reg_write) begin
                obs[5]++;
                obs[6] = c;
                obs[7] = int'(bus.wb_sel);
            end
            if (bus.data_mem_req) begin
                obs[8]++;
                obs[9] = int'(bus.data_mem_write);
            end
            if (c == fw + 3) begin
                obs[10] = int'(bus.alu_control);
                obs[11] = int'(bus.alu_src_a);
                obs[12] = int'(bus.alu_src_b);
                obs[13] = int'(bus.imm_type);
            end
            if (bus.fault)   obs[14] = 1;
            if (bus.illegal) obs[15] = 1;
            if (bus.instr_mem_req && !bus.mem_ready) fwaits++;
            if (bus.data_mem_req && !bus.mem_ready)  mwaits++;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        check("instr_completed", 32'(done), 32'd1);
        for (int i = 0; i < N_ITEMS; i++) begin
            e = exp_q.pop_front();
            if (e[32]) check(tag_of(i), 32'(obs[i]), e[31:0]);
        end
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        int req_cnt, first_fault, cnt, n_ops, pcw;
        bit found, ir_seen;
        logic [31:0] ins;

        rst = 1'b1;
        drive_instr(32'h00208063, 1'b1, 1'b1, 1'b1);
        bus.mem_ready = 1'b1;
        do_reset("initial", 1'b1);

        // Directed instructions
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);   // ADD
        run_instr(32'h402081B3, 0, 0, 0, 0, 0);   // SUB
        run_instr(32'h0000A183, 0, 3, 0, 0, 0);   // LW, 3 wait states
        run_instr(32'h0030A023, 1, 2, 0, 0, 0);   // SW
        run_instr(32'h00208063, 0, 0, 1, 0, 0);   // BEQ taken
        run_instr(32'h00208063, 0, 0, 0, 0, 0);   // BEQ not taken
        run_instr(32'h0020E063, 0, 0, 0, 0, 1);   // BLTU taken
        run_instr(32'h0020A063, 0, 0, 1, 1, 1);   // func3 010: never taken
        run_instr(32'h000080E7, 0, 0, 0, 0, 0);   // JALR
        run_instr(32'h008000EF, 2, 0, 0, 0, 0);   // JAL
        run_instr(32'h000011B7, 0, 0, 0, 0, 0);   // LUI
        run_instr(32'h00001197, 0, 0, 0, 0, 0);   // AUIPC
        run_instr(32'h4010D193, 0, 0, 0, 0, 0);   // SRAI
        run_instr(32'h40108193, 0, 0, 0, 0, 0);   // ADDI with IR[30] set
        run_instr(32'h0000A183, TO - 1, TO - 1, 0, 0, 0);  // ready on the limit cycle
`ifndef CONTROLLER_ILLEGAL_TRAP_EN
        run_instr(32'h0000007F, 0, 0, 0, 0, 0);   // unrecognised opcode as NOP
`endif

        // Randomized instructions
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        n_ops = 9;
`else
        n_ops = 12;
`endif
        for (int k = 0; k < N_RANDOM; k++) begin
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, n_ops - 1)];
            run_instr(ins, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // Fetch timeout with mem_ready stuck low
        drive_instr(32'h002081B3, 0, 0, 0);
        bus.mem_ready = 1'b0;
        req_cnt = 0;
        first_fault = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.instr_mem_req) req_cnt++;
            if (bus.fault && first_fault == 0) first_fault = c;
            @(posedge clk);
            #1;
        end
        check("timeout_req_cycles", 32'(req_cnt), 32'(TO));
        check("timeout_fault_cycle", 32'(first_fault), 32'(TO + 1));
        @(negedge clk);
        check("halt_fault", 32'(bus.fault), 32'd1);
        check("halt_strobes", outs_no_flags(), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.instr_mem_req || bus.ir_write || !bus.fault) cnt++;
            @(posedge clk);
            #1;
        end
        check("halt_holds", 32'(cnt), 32'd0);
        do_reset("after_halt", 1'b0);
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);

        // Reset asserted while a store waits in MEM
        drive_instr(32'h0030A023, 0, 0, 0);
        found = 0;
        for (int c = 1; c <= 10 && !found; c++) begin
            bus.mem_ready = bus.instr_mem_req;
            @(negedge clk);
            if (bus.data_mem_req) found = 1;
            @(posedge clk);
            #1;
        end
        check("reach_mem_state", 32'(found), 32'd1);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_pc_write", 32'(bus.pc_write), 32'd0);
        check("rst_mid_mem_reg_write", 32'(bus.reg_write), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_mid_mem_fetch", 32'(bus.instr_mem_req), 32'd1);
        check("rst_mid_mem_no_dreq", 32'(bus.data_mem_req), 32'd0);
        run_instr(32'h0000A183, 0, 1, 0, 0, 0);

`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        // Unrecognised opcode traps
        drive_instr(32'h0000007F, 0, 0, 0);
        ir_seen = 0;
        req_cnt = 0;
        pcw = 0;
        for (int c = 1; c <= 8; c++) begin
            bus.mem_ready = bus.instr_mem_req;
            @(negedge clk);
            if (ir_seen && bus.instr_mem_req) req_cnt++;
            if (bus.ir_write) ir_seen = 1;
            if (bus.pc_write) pcw++;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("trap_fetched", 32'(ir_seen), 32'd1);
        check("trap_no_refetch", 32'(req_cnt), 32'd0);
        check("trap_no_pc_write", 32'(pcw), 32'd0);
        check("trap_illegal", 32'(bus.illegal), 32'd1);
        check("trap_no_fault", 32'(bus.fault), 32'd0);
        check("trap_strobes", outs_no_flags(), 32'd0);
        @(posedge clk);
        #1;
        do_reset("after_trap", 1'b0);
        check("trap_illegal_cleared", 32'(bus.illegal), 32'd0);
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
